// File: rtl/trigger_gen.sv
// Trigger request generator for the CPU: a debounced push-button or a programmable
// periodic timer raises trigger_o, which holds until the CPU acknowledges it.
module trigger_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PERIOD_W        = 24,
    parameter int COUNT_W         = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                btn_i,
    input  logic                auto_en_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                ack_i,
    output logic                trigger_o,
    output logic                busy_o,
    output logic                miss_o,
    output logic [COUNT_W-1:0]  trig_count_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic                sync1_q,   sync1_d;
    logic                sync2_q,   sync2_d;
    logic                btn_db_q,  btn_db_d;
    logic                btn_prev_q, btn_prev_d;
    logic [DB_W-1:0]     db_cnt_q,  db_cnt_d;
    logic [PERIOD_W-1:0] pc_q,      pc_d;
    logic                trigger_q, trigger_d;
    logic                busy_q,    busy_d;
    logic                miss_q,    miss_d;
    logic [COUNT_W-1:0]  count_q,   count_d;

    logic btn_s;
    logic btn_req;
    logic auto_run;
    logic auto_req;
    logic req;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the block can infer a latch.
        state_d    = state_q;
        db_cnt_d   = '0;
        btn_db_d   = btn_db_q;
        pc_d       = '0;
        miss_d     = 1'b0;
        count_d    = count_q;

        sync1_d    = btn_i;
        sync2_d    = sync1_q;
        btn_s      = sync2_q;

        // The button level is accepted only after DEBOUNCE_CYCLES disagreeing samples in a row.
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        btn_prev_d = btn_db_q;
        btn_req    = btn_db_q & ~btn_prev_q;

        // The >= compare makes a shortened period fire immediately instead of overrunning.
        auto_run   = auto_en_i && (period_i != '0);
        auto_req   = auto_run && (pc_q >= (period_i - PERIOD_W'(1)));
        if (auto_run && !auto_req) begin
            pc_d = pc_q + PERIOD_W'(1);
        end

        req = btn_req | auto_req;

        unique case (state_q)
            IDLE: begin
                if (req) state_d = PEND;
            end
            PEND: begin
                miss_d = req;
                if (ack_i) begin
                    state_d = HOLD;
                    count_d = count_q + COUNT_W'(1);
                end
            end
            HOLD: begin
                miss_d  = req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        trigger_d = (state_d == PEND);
        busy_d    = (state_d != IDLE);
    end

    // NOTE: state updates use <= so every flop samples the values from before this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_db_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            db_cnt_q   <= '0;
            pc_q       <= '0;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            miss_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            btn_db_q   <= btn_db_d;
            btn_prev_q <= btn_prev_d;
            db_cnt_q   <= db_cnt_d;
            pc_q       <= pc_d;
            trigger_q  <= trigger_d;
            busy_q     <= busy_d;
            miss_q     <= miss_d;
            count_q    <= count_d;
        end
    end

    assign trigger_o    = trigger_q;
    assign busy_o       = busy_q;
    assign miss_o       = miss_q;
    assign trig_count_o = count_q;

endmodule

// File: tb/tb_trigger_gen.sv
// Scoreboard bench for trigger_gen: stimulus queues hand-computed events (trigger rise,
// miss pulse, count change) with their cycle; a monitor pops and compares them.
module tb_trigger_gen;

    localparam int DB  = 4;
    localparam int PW  = 24;
    localparam int CW  = 8;

    typedef enum int {EV_RISE, EV_MISS, EV_COUNT} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          btn_i;
    logic          auto_en_i;
    logic [PW-1:0] period_i;
    logic          ack_i;
    logic          trigger_o;
    logic          busy_o;
    logic          miss_o;
    logic [CW-1:0] trig_count_o;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    trigger_gen #(
        .DEBOUNCE_CYCLES(DB),
        .PERIOD_W       (PW),
        .COUNT_W        (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .btn_i       (btn_i),
        .auto_en_i   (auto_en_i),
        .period_i    (period_i),
        .ack_i       (ack_i),
        .trigger_o   (trigger_o),
        .busy_o      (busy_o),
        .miss_o      (miss_o),
        .trig_count_o(trig_count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void push(input ev_kind_t k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input ev_kind_t k, input int v);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got %s value %0d at cycle %0d, expected none",
                     k.name(), v, cyc);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("event_kind(%s)", e.kind.name()), k, e.kind);
            check($sformatf("event_cycle(%s)", e.kind.name()), cyc, e.cyc);
            check($sformatf("event_value(%s)", e.kind.name()), v, e.val);
        end
    endtask

    // Monitor: one observation per DUT event, sampled on the falling edge.
    initial begin
        logic          prev_trig;
        logic [CW-1:0] prev_count;
        prev_trig  = 1'b0;
        prev_count = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (miss_o) observe(EV_MISS, 0);
                if (trig_count_o != prev_count) observe(EV_COUNT, int'(trig_count_o));
                if (trigger_o && !prev_trig) observe(EV_RISE, 0);
            end
            prev_trig  = trigger_o;
            prev_count = trig_count_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        rst_i     = 1'b1;
        btn_i     = 1'b1;
        auto_en_i = 1'b1;
        period_i  = '0;
        ack_i     = 1'b0;

        // 1: outputs stay 0 under reset; button rises DB+3 edges after release.
        repeat (2) begin
            @(negedge clk);
            check("rst_trigger", trigger_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_miss", miss_o, 0);
            check("rst_count", trig_count_o, 0);
        end
        mon_en = 1'b1;
        rst_i  = 1'b0;
        push(EV_RISE, cyc + DB + 3, 0);
        tick(DB + 4);
        push(EV_COUNT, cyc + 1, 1);
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        btn_i = 1'b0;
        tick(12);

        // 2: short glitches never get through; a held press fires 7 edges later.
        repeat (5) begin
            btn_i = 1'b1;
            tick(3);
            btn_i = 1'b0;
            tick(1);
        end
        btn_i = 1'b1;
        push(EV_RISE, cyc + 7, 0);
        tick(8);
        push(EV_COUNT, cyc + 1, 2);
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        btn_i = 1'b0;
        tick(12);

        // 3: period 10, ack two cycles after each trigger.
        push(EV_COUNT, cyc + 1, 0);
        rst_i     = 1'b1;
        period_i  = PW'(10);
        auto_en_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        r = cyc;
        for (int i = 0; i < 3; i++) begin
            push(EV_RISE, r + 10 + 10 * i, 0);
            push(EV_COUNT, r + 12 + 10 * i, i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            wait_cyc(r + 11 + 10 * i);
            ack_i = 1'b1;
            tick(1);
            ack_i = 1'b0;
        end
        auto_en_i = 1'b0;
        tick(5);

        // 4: period 3 without ack: trigger holds, misses every 3 cycles, then HOLD gap.
        push(EV_COUNT, cyc + 1, 0);
        rst_i     = 1'b1;
        period_i  = PW'(3);
        auto_en_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        r = cyc;
        push(EV_RISE, r + 3, 0);
        push(EV_MISS, r + 6, 0);
        push(EV_MISS, r + 9, 0);
        push(EV_MISS, r + 12, 0);
        push(EV_MISS, r + 15, 0);
        push(EV_COUNT, r + 16, 1);
        push(EV_RISE, r + 18, 0);
        push(EV_COUNT, r + 19, 2);
        wait_cyc(r + 15);
        ack_i = 1'b1;
        tick(1);
        check("hold_trigger", trigger_o, 0);
        check("hold_busy", busy_o, 1);
        check("hold_count", trig_count_o, 1);
        tick(1);
        check("idle_busy", busy_o, 0);
        tick(1);
        auto_en_i = 1'b0;
        tick(1);
        ack_i = 1'b0;
        tick(5);

        // 5: button edge and auto request in the same cycle count once.
        push(EV_COUNT, cyc + 1, 0);
        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        r = cyc;
        btn_i     = 1'b1;
        auto_en_i = 1'b1;
        period_i  = PW'(7);
        push(EV_RISE, r + 7, 0);
        push(EV_COUNT, r + 8, 1);
        wait_cyc(r + 7);
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        tick(1);
        auto_en_i = 1'b0;
        btn_i     = 1'b0;
        tick(12);

        // 6: counter wraps after 256 acks, then reset while PEND clears everything.
        push(EV_COUNT, cyc + 1, 0);
        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        r = cyc;
        period_i  = PW'(3);
        auto_en_i = 1'b1;
        ack_i     = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            push(EV_RISE, r + 3 + 3 * i, 0);
            push(EV_COUNT, r + 4 + 3 * i, (i + 1) % 256);
        end
        push(EV_RISE, r + 774, 0);
        push(EV_COUNT, r + 775, 0);
        wait_cyc(r + 773);
        ack_i = 1'b0;
        tick(1);
        check("pend_before_reset", busy_o, 1);
        rst_i     = 1'b1;
        auto_en_i = 1'b0;
        tick(1);
        check("reset_pend_trigger", trigger_o, 0);
        check("reset_pend_busy", busy_o, 0);
        check("reset_pend_count", trig_count_o, 0);
        tick(1);
        rst_i = 1'b0;
        tick(6);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
